// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO models: legal data widths, skid-buffer depth
// and the occupancy counter width.
package fifo_pkg;

    localparam int DW_9      = 9;
    localparam int DW_18     = 18;
    localparam int DW_36     = 36;
    localparam int BUF_DEPTH = 2;
    localparam int OCC_W     = 2;

    typedef logic [OCC_W-1:0] occ_t;

    function automatic bit legal_width(input int w);
        return (w == DW_9) || (w == DW_18) || (w == DW_36);
    endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry in-order buffer with 1-bit wrapping pointers and an occupancy count.
// Data storage is deliberately not reset; only pointers and occupancy are.
module fifo_rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 36
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output occ_t                  occ_o
);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    occ_t                  occ_q;
    logic                  wr_ok;
    logic                  rd_ok;

    // A write into a full buffer is only taken when the same cycle frees a slot.
    assign wr_ok = wr_en_i & ((occ_q != occ_t'(BUF_DEPTH)) | rd_en_i);
    assign rd_ok = rd_en_i & (occ_q != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= ~wr_ptr_q;
            if (rd_ok) rd_ptr_q <= ~rd_ptr_q;
            occ_q <= occ_q + occ_t'(wr_ok) - occ_t'(rd_ok);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok && !clear_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign occ_o     = occ_q;

endmodule

// File: rtl/fifo_rd_streamer.sv
// Turns a 1-cycle-latency FIFO read port into a valid/ready stream at 1 beat/cycle.
// Optional sticky error flag enabled by defining FIFO_RD_STREAMER_ERR_EN.
module fifo_rd_streamer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 36
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  CLEAR,
    input  logic                  FIFO_EMPTY,
    input  logic                  FIFO_UNDERFLOW,
    input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
    output logic                  FIFO_RD_EN,
    output logic                  M_VALID,
    input  logic                  M_READY,
    output logic [DATA_WIDTH-1:0] M_DATA,
    output logic                  ERR
);

    if (!legal_width(DATA_WIDTH)) begin : g_bad_width
        $error("fifo_rd_streamer: DATA_WIDTH %0d is not one of 9, 18, 36", DATA_WIDTH);
    end

    occ_t       occ;
    logic       inflight_q;
    logic       pop;
    logic       room;

    assign M_VALID = (occ != '0);
    assign pop     = M_VALID & M_READY;
    // Room for one more word counting the one already requested; a pop frees a slot now.
    assign room    = ({1'b0, occ} + {2'b00, inflight_q}) < 3'd2;
    assign FIFO_RD_EN = RESET_N & ~FIFO_EMPTY & ~CLEAR & (room | pop);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) inflight_q <= 1'b0;
        else          inflight_q <= FIFO_RD_EN;
    end

    fifo_rd_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk_i     (CLK),
        .rst_ni    (RESET_N),
        .clear_i   (CLEAR),
        .wr_en_i   (inflight_q),
        .wr_data_i (FIFO_RD_DATA),
        .rd_en_i   (pop),
        .rd_data_o (M_DATA),
        .occ_o     (occ)
    );

`ifdef FIFO_RD_STREAMER_ERR_EN
    logic err_q;
    logic overflow;

    assign overflow = inflight_q & (occ == occ_t'(BUF_DEPTH)) & ~pop;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)                         err_q <= 1'b0;
        else if (CLEAR)                       err_q <= 1'b0;
        else if (FIFO_UNDERFLOW || overflow)  err_q <= 1'b1;
    end

    assign ERR = err_q;
`else
    logic unused_underflow;
    assign unused_underflow = FIFO_UNDERFLOW;
    assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Directed bench for fifo_rd_streamer: queue model of the upstream FIFO and of
// words taken but not yet delivered, checked on every falling edge.
module tb_fifo_rd_streamer;

  localparam int W = 36;

  logic         CLK = 1'b0;
  logic         RESET_N = 1'b0;
  logic         CLEAR = 1'b0;
  logic         FIFO_EMPTY = 1'b1;
  logic         FIFO_UNDERFLOW = 1'b0;
  logic [W-1:0] FIFO_RD_DATA = '0;
  logic         FIFO_RD_EN;
  logic         M_VALID;
  logic         M_READY = 1'b0;
  logic [W-1:0] M_DATA;
  logic         ERR;

  int n_tests = 0;
  int n_fail = 0;

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  logic         pend = 1'b0;
  logic [W-1:0] pend_data = '0;
  logic         hold_pending = 1'b0;
  logic [W-1:0] hold_data = '0;
  int           cyc = 0;
  int           beats = 0;
  int           gaps = 0;
  int           last_beat_cyc = 0;
  logic [W-1:0] first_beat_data = '0;
  logic [W-1:0] last_beat_data = '0;
  logic         err_exp;

`ifdef FIFO_RD_STREAMER_ERR_EN
  assign err_exp = 1'b1;
`else
  assign err_exp = 1'b0;
`endif

  always #5 CLK = ~CLK;

  fifo_rd_streamer #(.DATA_WIDTH(W)) dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .CLEAR          (CLEAR),
    .FIFO_EMPTY     (FIFO_EMPTY),
    .FIFO_UNDERFLOW (FIFO_UNDERFLOW),
    .FIFO_RD_DATA   (FIFO_RD_DATA),
    .FIFO_RD_EN     (FIFO_RD_EN),
    .M_VALID        (M_VALID),
    .M_READY        (M_READY),
    .M_DATA         (M_DATA),
    .ERR            (ERR)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard: every presented beat must be the oldest word taken from the FIFO
  always @(negedge CLK) begin
    cyc++;
    if (!RESET_N) begin
      exp_q.delete();
      hold_pending = 1'b0;
      pend = 1'b0;
    end else begin
      check("rd_en_while_empty", 64'(FIFO_RD_EN & FIFO_EMPTY), 64'(0));
      if (hold_pending) begin
        check("hold_valid", 64'(M_VALID), 64'(1));
        check("hold_data", 64'(M_DATA), 64'(hold_data));
      end
      if (M_VALID) begin
        if (exp_q.size() == 0) begin
          check("beat_unexpected", 64'(M_VALID), 64'(0));
        end else begin
          check("beat_data", 64'(M_DATA), 64'(exp_q[0]));
          if (M_READY) begin
            void'(exp_q.pop_front());
            if (beats > 0 && cyc != last_beat_cyc + 1) gaps++;
            if (beats == 0) first_beat_data = M_DATA;
            last_beat_data = M_DATA;
            beats++;
            last_beat_cyc = cyc;
          end
        end
      end
      hold_pending = M_VALID & ~M_READY & ~CLEAR;
      hold_data = M_DATA;
      if (CLEAR) exp_q.delete();
      if (FIFO_RD_EN && !FIFO_EMPTY && fifo_q.size() > 0) begin
        pend_data = fifo_q.pop_front();
        pend = 1'b1;
        exp_q.push_back(pend_data);
      end
    end
  end

  // upstream FIFO: read data appears in the cycle after the read enable
  always @(posedge CLK) begin
    #1;
    if (pend) begin
      FIFO_RD_DATA = pend_data;
      pend = 1'b0;
    end
    FIFO_EMPTY = (fifo_q.size() == 0);
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic sample();
    @(negedge CLK);
    #1;
  endtask

  task automatic push(input logic [W-1:0] w);
    fifo_q.push_back(w);
    FIFO_EMPTY = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k;
    k = 0;
    while (beats < n && k < budget) begin
      tick();
      k++;
    end
    if (beats < n) check("beat_timeout", 64'(beats), 64'(n));
  endtask

  initial begin
    // reset
    repeat (3) @(posedge CLK);
    #2;
    check("reset_valid", 64'(M_VALID), 64'(0));
    check("reset_rd_en", 64'(FIFO_RD_EN), 64'(0));
    check("reset_err", 64'(ERR), 64'(0));
    RESET_N = 1'b1;
    tick();
    tick();

    // first-word latency
    M_READY = 1'b1;
    beats = 0;
    push(36'h123456789);
    sample();
    check("fw_rd_en_n", 64'(FIFO_RD_EN), 64'(1));
    tick();
    sample();
    check("fw_rd_en_n1", 64'(FIFO_RD_EN), 64'(0));
    check("fw_valid_n1", 64'(M_VALID), 64'(0));
    tick();
    sample();
    check("fw_valid_n2", 64'(M_VALID), 64'(1));
    check("fw_data_n2", 64'(M_DATA), 64'h123456789);
    tick();
    tick();

    // sustained throughput
    beats = 0;
    gaps = 0;
    for (int i = 0; i < 16; i++) push(36'hA00000000 + 36'(i));
    wait_beats(16, 40);
    check("tp_beats", 64'(beats), 64'(16));
    check("tp_gaps", 64'(gaps), 64'(0));
    check("tp_first", 64'(first_beat_data), 64'hA00000000);
    check("tp_last", 64'(last_beat_data), 64'hA0000000F);
    tick();

    // backpressure: 5 cycles of M_READY low after the third beat
    beats = 0;
    for (int i = 0; i < 12; i++) push(36'hB00000000 + 36'(i));
    wait_beats(3, 20);
    M_READY = 1'b0;
    sample();
    check("bp_held_data0", 64'(M_DATA), 64'hB00000003);
    repeat (3) tick();
    sample();
    check("bp_rd_en_stopped", 64'(FIFO_RD_EN), 64'(0));
    check("bp_valid", 64'(M_VALID), 64'(1));
    check("bp_held_data3", 64'(M_DATA), 64'hB00000003);
    tick();
    tick();
    M_READY = 1'b1;
    wait_beats(12, 40);
    check("bp_beats", 64'(beats), 64'(12));
    check("bp_last", 64'(last_beat_data), 64'hB0000000B);
    tick();

    // CLEAR with the buffer full
    beats = 0;
    M_READY = 1'b0;
    for (int i = 0; i < 6; i++) push(36'hC00000000 + 36'(i));
    repeat (4) tick();
    check("clr_full_valid", 64'(M_VALID), 64'(1));
    check("clr_full_data", 64'(M_DATA), 64'hC00000000);
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    sample();
    check("clr_full_valid_after", 64'(M_VALID), 64'(0));
    M_READY = 1'b1;
    wait_beats(4, 30);
    check("clr_full_next", 64'(first_beat_data), 64'hC00000002);
    check("clr_full_last", 64'(last_beat_data), 64'hC00000005);
    tick();

    // CLEAR while streaming: one buffered word and one in flight are dropped
    beats = 0;
    for (int i = 0; i < 8; i++) push(36'hD00000000 + 36'(i));
    wait_beats(3, 20);
    M_READY = 1'b0;
    CLEAR = 1'b1;
    beats = 0;
    tick();
    CLEAR = 1'b0;
    sample();
    check("clr_fly_valid_after", 64'(M_VALID), 64'(0));
    M_READY = 1'b1;
    wait_beats(3, 30);
    check("clr_fly_next", 64'(first_beat_data), 64'hD00000005);
    check("clr_fly_last", 64'(last_beat_data), 64'hD00000007);
    tick();

    // sticky error flag
    FIFO_UNDERFLOW = 1'b1;
    tick();
    FIFO_UNDERFLOW = 1'b0;
    sample();
    check("err_set", 64'(ERR), 64'(err_exp));
    repeat (3) tick();
    check("err_sticky", 64'(ERR), 64'(err_exp));
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    sample();
    check("err_cleared", 64'(ERR), 64'(0));
    tick();

    // asynchronous reset with the buffer full
    beats = 0;
    M_READY = 1'b0;
    for (int i = 0; i < 4; i++) push(36'hE00000000 + 36'(i));
    FIFO_UNDERFLOW = 1'b1;
    tick();
    FIFO_UNDERFLOW = 1'b0;
    repeat (3) tick();
    check("rst_pre_valid", 64'(M_VALID), 64'(1));
    check("rst_pre_err", 64'(ERR), 64'(err_exp));
    RESET_N = 1'b0;
    #1;
    check("rst_mid_valid", 64'(M_VALID), 64'(0));
    check("rst_mid_rd_en", 64'(FIFO_RD_EN), 64'(0));
    check("rst_mid_err", 64'(ERR), 64'(0));
    tick();
    RESET_N = 1'b1;
    M_READY = 1'b1;
    wait_beats(2, 30);
    check("rst_next", 64'(first_beat_data), 64'hE00000002);
    check("rst_last", 64'(last_beat_data), 64'hE00000003);
    repeat (4) tick();
    check("end_no_leftover", 64'(exp_q.size()), 64'(0));
    check("end_valid", 64'(M_VALID), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
